// File: rtl/lcd_bin2bcd.sv
// lcd_bin2bcd: sequential binary-to-packed-BCD converter feeding the LCD drive block.
// Latency: BIN_STB at edge N -> VAL_* and VAL_STB after edge N+1+SPO2_BITS+HEART_BITS+WATT_BITS.
// Backpressure: none; a strobe while BUSY is held as one pending request (latest wins).
// Ports: CLK/XRST clock and async active-low reset; BIN_* binary inputs + BIN_STB;
//        VAL_SPO2/VAL_HEARTRATE (3 BCD digits), VAL_WATT (5 BCD digits), VAL_STB pulse, BUSY.
// Optional: define LCD_BCD_LZB_EN for leading-zero blanking (blank code 4'hF) on the output copy.
module lcd_bin2bcd #(
  parameter int SPO2_BITS  = 10,
  parameter int HEART_BITS = 10,
  parameter int WATT_BITS  = 17
) (
  input  logic                  CLK,
  input  logic                  XRST,
  input  logic [SPO2_BITS-1:0]  BIN_SPO2,
  input  logic [HEART_BITS-1:0] BIN_HEART,
  input  logic [WATT_BITS-1:0]  BIN_WATT,
  input  logic                  BIN_STB,
  output logic [11:0]           VAL_SPO2,
  output logic [11:0]           VAL_HEARTRATE,
  output logic [19:0]           VAL_WATT,
  output logic                  VAL_STB,
  output logic                  BUSY
);

  // Shared engine width: the widest of the three binary fields.
  localparam int EW = (SPO2_BITS > HEART_BITS) ?
                      ((SPO2_BITS > WATT_BITS) ? SPO2_BITS : WATT_BITS) :
                      ((HEART_BITS > WATT_BITS) ? HEART_BITS : WATT_BITS);
  localparam int CW = $clog2(EW + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                state;
  logic [1:0]            field;
  logic [CW-1:0]         cnt;
  logic [EW-1:0]         bin_sr;
  logic [19:0]           bcd_sr;
  logic [HEART_BITS-1:0] cap_heart;
  logic [WATT_BITS-1:0]  cap_watt;
  logic                  pend_vld;
  logic [SPO2_BITS-1:0]  pend_spo2;
  logic [HEART_BITS-1:0] pend_heart;
  logic [WATT_BITS-1:0]  pend_watt;
  logic [11:0]           shd_spo2;
  logic [11:0]           shd_heart;
  logic [19:0]           shd_watt;

  logic [SPO2_BITS-1:0]  sat_spo2;
  logic [HEART_BITS-1:0] sat_heart;
  logic [WATT_BITS-1:0]  sat_watt;
  logic [SPO2_BITS-1:0]  ld_spo2;
  logic [HEART_BITS-1:0] ld_heart;
  logic [WATT_BITS-1:0]  ld_watt;
  logic                  start;
  logic [19:0]           bcd_adj;
  logic [19:0]           bcd_next;
  logic [11:0]           fmt_spo2;
  logic [11:0]           fmt_heart;
  logic [19:0]           fmt_watt;

  // Saturation; a field too narrow to exceed its limit passes straight through.
  generate
    if (SPO2_BITS >= 10) begin : g_sat_spo2
      assign sat_spo2 = (BIN_SPO2 > SPO2_BITS'(999)) ? SPO2_BITS'(999) : BIN_SPO2;
    end else begin : g_pass_spo2
      assign sat_spo2 = BIN_SPO2;
    end
    if (HEART_BITS >= 10) begin : g_sat_heart
      assign sat_heart = (BIN_HEART > HEART_BITS'(999)) ? HEART_BITS'(999) : BIN_HEART;
    end else begin : g_pass_heart
      assign sat_heart = BIN_HEART;
    end
    if (WATT_BITS >= 17) begin : g_sat_watt
      assign sat_watt = (BIN_WATT > WATT_BITS'(99999)) ? WATT_BITS'(99999) : BIN_WATT;
    end else begin : g_pass_watt
      assign sat_watt = BIN_WATT;
    end
  endgenerate

  // Left-align a field in the engine so its MSB is shifted out first.
  function automatic logic [EW-1:0] align(input logic [EW-1:0] v, input int w);
    return v << (EW - w);
  endfunction

`ifdef LCD_BCD_LZB_EN
  // Blank leading zero digits of an nd-digit field; the units digit is always shown.
  function automatic logic [19:0] lzb(input logic [19:0] v, input int nd);
    logic lead;
    lzb  = v;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (i < nd) begin
        if (lead && (v[i*4 +: 4] == 4'd0)) lzb[i*4 +: 4] = 4'hF;
        else                               lead = 1'b0;
      end
    end
  endfunction
`endif

  always_comb begin
    // A fresh strobe always wins over queued data when a conversion starts.
    start    = ((state == IDLE) && BIN_STB) || ((state == DONE) && (BIN_STB || pend_vld));
    ld_spo2  = BIN_STB ? sat_spo2  : pend_spo2;
    ld_heart = BIN_STB ? sat_heart : pend_heart;
    ld_watt  = BIN_STB ? sat_watt  : pend_watt;

    bcd_adj = bcd_sr;
    for (int i = 0; i < 5; i++) begin
      if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[18:0], bin_sr[EW-1]};

    fmt_spo2  = shd_spo2;
    fmt_heart = shd_heart;
    fmt_watt  = shd_watt;
`ifdef LCD_BCD_LZB_EN
    fmt_spo2  = 12'(lzb({8'd0, shd_spo2}, 3));
    fmt_heart = 12'(lzb({8'd0, shd_heart}, 3));
    fmt_watt  = lzb(shd_watt, 5);
`endif
  end

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state         <= IDLE;
      field         <= 2'd0;
      cnt           <= '0;
      bin_sr        <= '0;
      bcd_sr        <= '0;
      cap_heart     <= '0;
      cap_watt      <= '0;
      pend_vld      <= 1'b0;
      pend_spo2     <= '0;
      pend_heart    <= '0;
      pend_watt     <= '0;
      shd_spo2      <= '0;
      shd_heart     <= '0;
      shd_watt      <= '0;
      VAL_SPO2      <= '0;
      VAL_HEARTRATE <= '0;
      VAL_WATT      <= '0;
      VAL_STB       <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      VAL_STB <= 1'b0;

      // Strobes during CONV queue up; DONE always consumes or overrides the queue.
      if ((state == CONV) && BIN_STB) begin
        pend_vld   <= 1'b1;
        pend_spo2  <= sat_spo2;
        pend_heart <= sat_heart;
        pend_watt  <= sat_watt;
      end else if (state == DONE) begin
        pend_vld <= 1'b0;
      end

      case (state)
        CONV: begin
          if (cnt == '0) begin
            // Last bit of this field: bank the result and load the next field now.
            bcd_sr <= '0;
            case (field)
              2'd0: begin
                shd_spo2 <= bcd_next[11:0];
                bin_sr   <= align(EW'(cap_heart), HEART_BITS);
                cnt      <= CW'(HEART_BITS - 1);
                field    <= 2'd1;
              end
              2'd1: begin
                shd_heart <= bcd_next[11:0];
                bin_sr    <= align(EW'(cap_watt), WATT_BITS);
                cnt       <= CW'(WATT_BITS - 1);
                field     <= 2'd2;
              end
              default: begin
                shd_watt <= bcd_next;
                state    <= DONE;
              end
            endcase
          end else begin
            bcd_sr <= bcd_next;
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - 1'b1;
          end
        end
        DONE: begin
          VAL_SPO2      <= fmt_spo2;
          VAL_HEARTRATE <= fmt_heart;
          VAL_WATT      <= fmt_watt;
          VAL_STB       <= 1'b1;
          if (!start) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (start) begin
        state     <= CONV;
        BUSY      <= 1'b1;
        field     <= 2'd0;
        cnt       <= CW'(SPO2_BITS - 1);
        bin_sr    <= align(EW'(ld_spo2), SPO2_BITS);
        bcd_sr    <= '0;
        cap_heart <= ld_heart;
        cap_watt  <= ld_watt;
      end
    end
  end

endmodule

// File: doc/lcd_bin2bcd.md
Name: lcd_bin2bcd

Overview:
Sequential binary-to-BCD converter between the APB LCD data register block and the LCD drive block. It takes binary SpO2, heart-rate and wattage values plus a strobe. It produces packed-BCD VAL_SPO2 (3 digits), VAL_HEARTRATE (3 digits) and VAL_WATT (5 digits) with a one-cycle VAL_STB, in exactly the format the LCD drive consumes. A single shared shift-add-3 (double-dabble) engine converts the three fields in sequence, one bit per clock.

Parameters:
SPO2_BITS, 10, binary width of BIN_SPO2 (1..10)
HEART_BITS, 10, binary width of BIN_HEART (1..10)
WATT_BITS, 17, binary width of BIN_WATT (1..17)

Ports:
CLK  in  1  conversion clock; all state on rising edge
XRST  in  1  reset, asynchronous, active-low
BIN_SPO2  in  SPO2_BITS  binary SpO2 value
BIN_HEART  in  HEART_BITS  binary heart rate
BIN_WATT  in  WATT_BITS  binary wattage
BIN_STB  in  1  input-valid pulse; inputs sampled on the edge where high
VAL_SPO2  out  12  BCD {hundreds,tens,units}
VAL_HEARTRATE  out  12  BCD {hundreds,tens,units}
VAL_WATT  out  20  BCD, 5 digits, MS digit in [19:16]
VAL_STB  out  1  one-cycle pulse: VAL_* just updated
BUSY  out  1  high while a conversion is in progress (states CONV, DONE)

Behaviour:
- Clock/reset: one clock CLK; XRST is an asynchronous, active-low reset.
- Reset (XRST=0, asynchronous): all VAL_* = 0, VAL_STB = 0, BUSY = 0, pending flag cleared, FSM = IDLE.
- Reset mid-conversion: the conversion and any pending request are discarded.
- FSM states: IDLE, CONV, DONE.
- IDLE: on an edge with BIN_STB=1, capture saturated inputs, select field 0 (SpO2), load the bit counter, go to CONV.
- Saturation at capture:
  - SpO2 > 999 -> 999; heart > 999 -> 999; watt > 99999 -> 99999.
  - Compare logic is omitted when the width cannot exceed the limit.
- CONV: one double-dabble step per edge on the active field.
  - Add 3 to every BCD nibble >= 5, then shift left one bit, MSB of the binary first.
  - After the field's last bit, write the field result to an internal shadow register and select the next field on the same edge (no idle cycle).
  - Order: SpO2, heart, watt.
- Cycle counts: CONV lasts SPO2_BITS+HEART_BITS+WATT_BITS edges (37 at defaults). After the final watt step -> DONE.
- DONE edge:
  - Copy all three shadow registers to VAL_* atomically and set VAL_STB=1 for exactly one cycle.
  - Then start a new conversion if one is requested, else go to IDLE.
- Latency: BIN_STB sampled at edge N -> VAL_* updated and VAL_STB high after edge N+38 (at defaults; generally N+1+sum of widths).
- VAL_* hold their value between updates; partial results are never visible.
- BIN_STB while BUSY (CONV, or DONE when DONE does not itself start from BIN_STB):
  - Inputs are captured into pending registers and the pending flag is set.
  - Later strobes overwrite them (latest wins); at most one conversion is queued.
- DONE start priority: BIN_STB on the DONE edge captures the fresh inputs directly, overriding pending data. Otherwise, if pending is set, the pending data is loaded and pending is cleared. Either way the FSM goes straight to CONV.
  - Back-to-back latency is therefore 38 cycles between VAL_STB pulses.
- BCD nibbles are always 0..9; no overflow is possible after saturation.

Optional Feature:
- Macro: LCD_BCD_LZB_EN
- Defined: leading-zero blanking on the DONE copy. Leading zero digits of each field become 4'hF (the LCD drive's blank code), scanning from the MS digit down. The units digit is never blanked, so 0 shows as "  0" = 12'hFF0 and 45 W shows as 20'hFFF45.
- Undefined: plain zero-padded BCD; blanking logic is absent. Latency is identical in both builds.

Test Plan:
- Reset then idle: XRST low -> all outputs 0, BUSY 0; release, no BIN_STB for 100 cycles -> VAL_STB never asserts.
- Basic conversion: BIN_SPO2=98, BIN_HEART=123, BIN_WATT=54321, BIN_STB at edge N -> VAL_STB only after edge N+38 with VAL_SPO2=12'h098, VAL_HEARTRATE=12'h123, VAL_WATT=20'h54321; BUSY high edges N..N+37.
- Saturation: BIN_SPO2=1023, BIN_HEART=1000, BIN_WATT=131071 -> 12'h999, 12'h999, 20'h99999.
- Queued request: first 11/22/33 at N, second 456/789/99999 at N+5, third 1/2/3 at N+9 -> pulses after N+38 (011/022/00033) and N+76 (001/002/00003); the second set is never output.
- Strobe on DONE edge: new strobe coincident with edge N+38 -> first result at N+38, new result at N+76, no IDLE cycle in between.
- Reset mid-CONV: XRST low at N+20 -> outputs 0, no VAL_STB afterwards, pending discarded; next BIN_STB converts normally. With LCD_BCD_LZB_EN, run basic conversion -> VAL_SPO2=12'hF98.
